// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812b pixel serializer.
// Timing defaults assume a 15.65 MHz system clock.
package ws2812_pkg;

   localparam int PIX_W              = 24;
   localparam int DEF_BIT_CYCLES     = 20;
   localparam int DEF_T0H_CYCLES     = 6;
   localparam int DEF_T1H_CYCLES     = 13;
   localparam int DEF_LATCH_CYCLES   = 800;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_LATCH = 2'd2
   } state_t;

endpackage

// File: rtl/ws2812_bit_timer.sv
// Per-bit cycle counter and high-phase compare for WS2812b bit encoding.
// The counter free-runs while run is high and wraps at the bit boundary.
module ws2812_bit_timer #(
   parameter int BIT_CYCLES = 20,
   parameter int T0H_CYCLES = 6,
   parameter int T1H_CYCLES = 13
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic run,
   input  logic bit_val,
   output logic level,
   output logic bit_end
);

   localparam int CYC_W = $clog2(BIT_CYCLES);

   logic [CYC_W-1:0] cyc_q;
   logic [CYC_W-1:0] cyc_d;

   always_comb begin
      bit_end = run && (cyc_q == CYC_W'(BIT_CYCLES - 1));
      level   = run && (cyc_q < (bit_val ? CYC_W'(T1H_CYCLES) : CYC_W'(T0H_CYCLES)));
      cyc_d   = cyc_q;
      if (!run || bit_end) begin
         cyc_d = '0;
      end else begin
         cyc_d = cyc_q + CYC_W'(1);
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cyc_q <= '0;
      end else begin
         cyc_q <= cyc_d;
      end
   end

endmodule

// File: rtl/ws2812_pixel_serializer.sv
// Serialises 24-bit GRB pixel words onto the WS2812b data line, MSB first,
// followed by a low latch interval after the last pixel of each frame.
module ws2812_pixel_serializer
   import ws2812_pkg::*;
#(
   parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
   parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
   parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
   parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic [PIX_W-1:0]  pix_data,
   input  logic              pix_last,
   input  logic              pix_valid,
   output logic              pix_ready,
   output logic              dout,
   output logic              busy,
   output logic              frame_done,
   output logic              underrun
);

   localparam int LAT_W = $clog2(LATCH_CYCLES + 1);

   state_t             state_q, state_d;
   logic [PIX_W-1:0]   sreg_q, sreg_d;
   logic               last_q, last_d;
   logic [4:0]         bit_idx_q, bit_idx_d;
   logic [LAT_W-1:0]   lat_q, lat_d;
   logic               dout_q, dout_d;
   logic               frame_done_q, frame_done_d;
   logic               underrun_q, underrun_d;
   logic               ready_c;
   logic               run;
   logic               level;
   logic               bit_end;

   ws2812_bit_timer #(
      .BIT_CYCLES (BIT_CYCLES),
      .T0H_CYCLES (T0H_CYCLES),
      .T1H_CYCLES (T1H_CYCLES)
   ) u_bit_timer (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .run       (run),
      .bit_val   (sreg_q[PIX_W-1]),
      .level     (level),
      .bit_end   (bit_end)
   );

   always_comb begin
      state_d      = state_q;
      sreg_d       = sreg_q;
      last_d       = last_q;
      bit_idx_d    = bit_idx_q;
      lat_d        = lat_q;
      dout_d       = 1'b0;
      frame_done_d = 1'b0;
      underrun_d   = 1'b0;
      ready_c      = 1'b0;
      run          = 1'b0;

      case (state_q)
         ST_IDLE: begin
            ready_c = 1'b1;
            if (pix_valid) begin
               state_d   = ST_SEND;
               sreg_d    = pix_data;
               last_d    = pix_last;
               bit_idx_d = 5'd23;
            end
         end

         ST_SEND: begin
            run    = 1'b1;
            dout_d = level;
            if (bit_end) begin
               if (bit_idx_q != 5'd0) begin
                  sreg_d    = sreg_q << 1;
                  bit_idx_d = bit_idx_q - 5'd1;
               end else if (!last_q) begin
                  // Accepting here chains the next pixel with no gap on the line.
                  ready_c = 1'b1;
                  if (pix_valid) begin
                     sreg_d    = pix_data;
                     last_d    = pix_last;
                     bit_idx_d = 5'd23;
                  end else begin
                     state_d    = ST_LATCH;
                     underrun_d = 1'b1;
                  end
               end else begin
                  state_d = ST_LATCH;
               end
            end
         end

         ST_LATCH: begin
            if (lat_q == LAT_W'(LATCH_CYCLES - 1)) begin
               state_d      = ST_IDLE;
               lat_d        = '0;
               frame_done_d = 1'b1;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= ST_IDLE;
         sreg_q       <= '0;
         last_q       <= 1'b0;
         bit_idx_q    <= '0;
         lat_q        <= '0;
         dout_q       <= 1'b0;
         frame_done_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sreg_q       <= sreg_d;
         last_q       <= last_d;
         bit_idx_q    <= bit_idx_d;
         lat_q        <= lat_d;
         dout_q       <= dout_d;
         frame_done_q <= frame_done_d;
         underrun_q   <= underrun_d;
      end
   end

   // Ready is forced low while reset is held, even though state sits at IDLE.
   assign pix_ready  = ready_c & sys_rst_n;
   assign dout       = dout_q;
   assign busy       = (state_q != ST_IDLE);
   assign frame_done = frame_done_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_ws2812_pixel_serializer.sv
// Directed bench for the WS2812b serializer: default timing on u_dut0,
// shortened timing (10/3/7/20) on u_dut1.
module tb_ws2812_pixel_serializer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] d0, d1;
   logic        l0, l1, v0, v1;
   logic        r0, r1, o0, o1, b0, b1, f0, f1, u0, u1;

   int n_cmp = 0;
   int n_bad = 0;
   int lead [48];
   int tot  [48];
   int fd_at, fd_cnt, ur_at, ur_cnt, rdy_at, rdy_cnt, late_hi;

   always #5 clk = ~clk;

   ws2812_pixel_serializer u_dut0 (
      .sys_clk    (clk),
      .sys_rst_n  (rst_n),
      .pix_data   (d0),
      .pix_last   (l0),
      .pix_valid  (v0),
      .pix_ready  (r0),
      .dout       (o0),
      .busy       (b0),
      .frame_done (f0),
      .underrun   (u0)
   );

   ws2812_pixel_serializer #(
      .BIT_CYCLES   (10),
      .T0H_CYCLES   (3),
      .T1H_CYCLES   (7),
      .LATCH_CYCLES (20)
   ) u_dut1 (
      .sys_clk    (clk),
      .sys_rst_n  (rst_n),
      .pix_data   (d1),
      .pix_last   (l1),
      .pix_valid  (v1),
      .pix_ready  (r1),
      .dout       (o1),
      .busy       (b1),
      .frame_done (f1),
      .underrun   (u1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Called on a negedge with the target DUT idle; returns on the negedge after the transfer edge.
   task automatic start_px(input bit inst, input logic [23:0] d, input logic l, input string tag);
      chk({tag, " ready before"}, 32'(inst ? r1 : r0), 32'd1);
      if (inst) begin v1 = 1'b1; d1 = d; l1 = l; end
      else      begin v0 = 1'b1; d0 = d; l0 = l; end
      @(negedge clk);
      chk({tag, " busy s0"}, 32'(inst ? b1 : b0), 32'd1);
      chk({tag, " dout s0"}, 32'(inst ? o1 : o0), 32'd0);
      $display("[%0t] %s: pixel %06h last=%0d accepted", $time, tag, d, l);
   endtask

   // Samples n negedges; dout at sample s reflects encoder cycle s-1 after the transfer edge.
   task automatic observe(input int n, input int nbits, input int bc, input bit inst,
                          input int drop_at, input int raise_at,
                          input logic [23:0] rdata, input logic rlast);
      bit   in_lead [48];
      int   slot;
      logic dv, fv, uv, rv;
      for (int i = 0; i < 48; i++) begin
         lead[i] = 0; tot[i] = 0; in_lead[i] = 1'b1;
      end
      fd_at = 0; fd_cnt = 0; ur_at = 0; ur_cnt = 0; rdy_at = 0; rdy_cnt = 0; late_hi = 0;
      for (int s = 1; s <= n; s++) begin
         @(negedge clk);
         dv = inst ? o1 : o0;
         fv = inst ? f1 : f0;
         uv = inst ? u1 : u0;
         rv = inst ? r1 : r0;
         if (s <= nbits * bc) begin
            slot = (s - 1) / bc;
            if (dv === 1'b1) begin
               tot[slot]++;
               if (in_lead[slot]) lead[slot]++;
            end else begin
               in_lead[slot] = 1'b0;
            end
         end else if (dv !== 1'b0) begin
            late_hi++;
         end
         if (fv === 1'b1) begin fd_cnt++;  if (fd_at == 0)  fd_at = s;  end
         if (uv === 1'b1) begin ur_cnt++;  if (ur_at == 0)  ur_at = s;  end
         if (rv === 1'b1) begin rdy_cnt++; if (rdy_at == 0) rdy_at = s; end
         if (s == drop_at) begin
            if (inst) v1 = 1'b0; else v0 = 1'b0;
         end
         if (s == raise_at) begin
            if (inst) begin v1 = 1'b1; d1 = rdata; l1 = rlast; end
            else      begin v0 = 1'b1; d0 = rdata; l0 = rlast; end
         end
      end
   endtask

   task automatic check_bits(input string tag, input logic [47:0] bits, input int nbits,
                             input int t0, input int t1);
      int stray;
      int w;
      stray = 0;
      for (int i = 0; i < nbits; i++) begin
         w = bits[nbits - 1 - i] ? t1 : t0;
         chk($sformatf("%s bit%0d high width", tag, i), 32'(lead[i]), 32'(w));
         stray += tot[i] - lead[i];
      end
      chk({tag, " stray highs"}, 32'(stray), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; l0 = 1'b0; l1 = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst dout",       32'(o0), 32'd0);
      chk("rst ready",      32'(r0), 32'd0);
      chk("rst busy",       32'(b0), 32'd0);
      chk("rst frame_done", 32'(f0), 32'd0);
      chk("rst underrun",   32'(u0), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle ready", 32'(r0), 32'd1);
      chk("idle busy",  32'(b0), 32'd0);

      // Single pixel, last frame word.
      start_px(1'b0, 24'hFF0000, 1'b1, "t1");
      v0 = 1'b0;
      observe(1280, 24, 20, 1'b0, -1, -1, 24'h0, 1'b0);
      check_bits("t1", 48'hFF0000, 24, 6, 13);
      chk("t1 latch dout highs", 32'(late_hi), 32'd0);
      chk("t1 frame_done at",    32'(fd_at),   32'd1280);
      chk("t1 frame_done count", 32'(fd_cnt),  32'd1);
      chk("t1 first ready at",   32'(rdy_at),  32'd1280);
      chk("t1 underrun count",   32'(ur_cnt),  32'd0);
      chk("t1 busy after",       32'(b0),      32'd0);
      @(negedge clk);
      chk("t1 frame_done low", 32'(f0), 32'd0);
      $display("[%0t] t1: frame done at %0d", $time, fd_at);

      // Back-to-back pixels with valid held high.
      start_px(1'b0, 24'hAAAAAA, 1'b0, "t2");
      d0 = 24'h555555; l0 = 1'b1;
      observe(1760, 48, 20, 1'b0, 480, -1, 24'h0, 1'b0);
      check_bits("t2", 48'hAAAAAA555555, 48, 6, 13);
      chk("t2 first ready at",   32'(rdy_at),  32'd479);
      chk("t2 ready count",      32'(rdy_cnt), 32'd2);
      chk("t2 latch dout highs", 32'(late_hi), 32'd0);
      chk("t2 frame_done at",    32'(fd_at),   32'd1760);
      chk("t2 underrun count",   32'(ur_cnt),  32'd0);
      $display("[%0t] t2: second pixel accepted at cycle 479, frame done at %0d", $time, fd_at);

      // Frame ends without pix_last.
      start_px(1'b0, 24'h000001, 1'b0, "t3");
      v0 = 1'b0;
      observe(1280, 24, 20, 1'b0, -1, -1, 24'h0, 1'b0);
      check_bits("t3", 48'h000001, 24, 6, 13);
      chk("t3 first ready at",   32'(rdy_at),  32'd479);
      chk("t3 ready count",      32'(rdy_cnt), 32'd2);
      chk("t3 underrun at",      32'(ur_at),   32'd480);
      chk("t3 underrun count",   32'(ur_cnt),  32'd1);
      chk("t3 frame_done at",    32'(fd_at),   32'd1280);
      chk("t3 latch dout highs", 32'(late_hi), 32'd0);
      chk("t3 ready idle",       32'(r0),      32'd1);
      $display("[%0t] t3: underrun at %0d", $time, ur_at);

      // Valid raised during LATCH; word must wait for IDLE.
      start_px(1'b0, 24'h123456, 1'b1, "t5");
      v0 = 1'b0;
      observe(1280, 24, 20, 1'b0, -1, 600, 24'h0F0F0F, 1'b1);
      check_bits("t5", 48'h123456, 24, 6, 13);
      chk("t5 first ready at", 32'(rdy_at),  32'd1280);
      chk("t5 ready count",    32'(rdy_cnt), 32'd1);
      chk("t5 frame_done at",  32'(fd_at),   32'd1280);
      @(negedge clk);
      chk("t5b busy s0", 32'(b0), 32'd1);
      v0 = 1'b0;
      observe(1280, 24, 20, 1'b0, -1, -1, 24'h0, 1'b0);
      check_bits("t5b", 48'h0F0F0F, 24, 6, 13);
      chk("t5b frame_done at", 32'(fd_at), 32'd1280);
      $display("[%0t] t5: held word sent after latch", $time);

      // Asynchronous reset in the middle of a high phase.
      start_px(1'b0, 24'hFFFFFF, 1'b1, "t4");
      v0 = 1'b0;
      observe(249, 12, 20, 1'b0, -1, -1, 24'h0, 1'b0);
      check_bits("t4", 48'hFFF, 12, 6, 13);
      @(negedge clk);
      chk("t4 dout before reset", 32'(o0), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("t4 dout async clear", 32'(o0), 32'd0);
      chk("t4 ready in reset",   32'(r0), 32'd0);
      chk("t4 busy in reset",    32'(b0), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t4 ready after", 32'(r0), 32'd1);
      chk("t4 busy after",  32'(b0), 32'd0);
      chk("t4 dout after",  32'(o0), 32'd0);
      $display("[%0t] t4: reset mid-pixel", $time);

      // Shortened timing instance.
      start_px(1'b1, 24'h800000, 1'b1, "t6");
      v1 = 1'b0;
      observe(260, 24, 10, 1'b1, -1, -1, 24'h0, 1'b0);
      check_bits("t6", 48'h800000, 24, 3, 7);
      chk("t6 latch dout highs", 32'(late_hi), 32'd0);
      chk("t6 frame_done at",    32'(fd_at),   32'd260);
      chk("t6 first ready at",   32'(rdy_at),  32'd260);
      $display("[%0t] t6: short-timing frame done at %0d", $time, fd_at);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
